// File: rtl/h14tx_pkg.sv
// Shared types for the h14tx video timing generator: timing struct, 720p60 preset,
// and total/validity helpers.
package h14tx_pkg;

  localparam int unsigned VtgBitWidth  = 12;
  localparam int unsigned VtgBitHeight = 11;

  typedef struct packed {
    logic [VtgBitWidth-1:0]  h_active;
    logic [VtgBitWidth-1:0]  h_fp;
    logic [VtgBitWidth-1:0]  h_sync;
    logic [VtgBitWidth-1:0]  h_bp;
    logic [VtgBitHeight-1:0] v_active;
    logic [VtgBitHeight-1:0] v_fp;
    logic [VtgBitHeight-1:0] v_sync;
    logic [VtgBitHeight-1:0] v_bp;
    logic                    hs_pol;
    logic                    vs_pol;
  } vtg_timing_t;

  localparam vtg_timing_t Vtg720p60 = '{
    h_active: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
    v_active: 11'd720,  v_fp: 11'd5,   v_sync: 11'd5,  v_bp: 11'd20,
    hs_pol:   1'b1,     vs_pol: 1'b1
  };

  // Largest total a counter of the given width can still step through (0..total-1).
  localparam logic [VtgBitWidth+1:0]  HTotalMax = {2'b01, {VtgBitWidth{1'b0}}};
  localparam logic [VtgBitHeight+1:0] VTotalMax = {2'b01, {VtgBitHeight{1'b0}}};

  function automatic logic [VtgBitWidth+1:0] vtg_h_total(input vtg_timing_t t);
    return {2'b00, t.h_active} + {2'b00, t.h_fp} + {2'b00, t.h_sync} + {2'b00, t.h_bp};
  endfunction

  function automatic logic [VtgBitHeight+1:0] vtg_v_total(input vtg_timing_t t);
    return {2'b00, t.v_active} + {2'b00, t.v_fp} + {2'b00, t.v_sync} + {2'b00, t.v_bp};
  endfunction

  function automatic logic vtg_valid(input vtg_timing_t t);
    return (t.h_active != '0) && (t.h_sync != '0) && (t.v_active != '0) && (t.v_sync != '0)
        && (vtg_h_total(t) <= HTotalMax) && (vtg_v_total(t) <= VTotalMax);
  endfunction

endpackage

// File: rtl/h14tx_delay_line.sv
// Synchronous-reset shift register with a per-bit reset value; Depth=0 is a plain wire.
module h14tx_delay_line #(
  parameter int unsigned      Width  = 1,
  parameter int unsigned      Depth  = 1,
  parameter logic [Width-1:0] RstVal = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  if (Depth == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_sr
    logic [Width-1:0] sr [Depth];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < Depth; i++) sr[i] <= RstVal;
      end else begin
        sr[0] <= d;
        for (int unsigned i = 1; i < Depth; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[Depth-1];
  end

endmodule

// File: rtl/h14tx_vtg.sv
// Runtime-programmable video timing generator: fetch coordinates x/y lead de/sync by Latency.
// Optional genlock input via `define H14TX_VTG_GENLOCK_EN.
module h14tx_vtg
  import h14tx_pkg::*;
#(
  parameter int unsigned BitWidth    = VtgBitWidth,
  parameter int unsigned BitHeight   = VtgBitHeight,
  parameter int unsigned Latency     = 2,
  parameter vtg_timing_t ResetTiming = Vtg720p60
) (
  input  logic                 clk,
  input  logic                 rst,
  input  vtg_timing_t          cfg,
  input  logic                 cfg_load,
  output logic                 cfg_pending,
  output logic                 cfg_err,
  output logic [BitWidth-1:0]  x,
  output logic [BitHeight-1:0] y,
  output logic                 de,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 sof,
  output logic                 eol
`ifdef H14TX_VTG_GENLOCK_EN
  ,
  input  logic                 ext_lock,
  output logic                 locked
`endif
);

  localparam int unsigned HW = BitWidth + 2;
  localparam int unsigned VW = BitHeight + 2;
  localparam logic [4:0] VidRst = {1'b0, ~ResetTiming.hs_pol, ~ResetTiming.vs_pol, 2'b00};

  vtg_timing_t          act, shd;
  logic [BitWidth-1:0]  hc, h_last;
  logic [BitHeight-1:0] vc, v_last;
  logic [HW-1:0]        htot, hs_beg, hs_end;
  logic [VW-1:0]        vtot, vs_beg, vs_end;
  logic                 line_end, frame_end, load_ok, jump;
  logic                 pend_q, err_q;
  logic                 de_raw, hs_raw, vs_raw, sof_raw, eol_raw;
  logic [4:0]           vid_d, vid_q;

  always_comb begin
    htot      = vtg_h_total(act);
    vtot      = vtg_v_total(act);
    hs_beg    = {2'b00, act.h_active} + {2'b00, act.h_fp};
    hs_end    = hs_beg + {2'b00, act.h_sync};
    vs_beg    = {2'b00, act.v_active} + {2'b00, act.v_fp};
    vs_end    = vs_beg + {2'b00, act.v_sync};
    h_last    = BitWidth'(htot - HW'(1));
    v_last    = BitHeight'(vtot - VW'(1));
    line_end  = (hc == h_last);
    frame_end = line_end && (vc == v_last);
    load_ok   = cfg_load && vtg_valid(cfg);
  end

`ifdef H14TX_VTG_GENLOCK_EN
  logic ext_q, near_vs;

  // Edge lands within one cycle of where the natural count would already reach vsync start.
  always_comb begin
    near_vs = (({2'b00, vc} + VW'(1) == vs_beg) && (line_end || (hc == h_last - BitWidth'(1))))
           || (({2'b00, vc} == vs_beg) && (hc == '0));
  end

  assign jump = ext_lock & ~ext_q;

  // ext_q keeps tracking during reset so an edge coinciding with rst is swallowed.
  always_ff @(posedge clk) begin
    ext_q <= ext_lock;
    if (rst)       locked <= 1'b0;
    else if (jump) locked <= near_vs;
  end
`else
  assign jump = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hc     <= '0;
      vc     <= '0;
      act    <= ResetTiming;
      shd    <= ResetTiming;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= cfg_load && !load_ok;
      if (jump) begin
        hc <= '0;
        vc <= BitHeight'(vs_beg);
        if (load_ok) begin
          shd    <= cfg;
          pend_q <= 1'b1;
        end
      end else if (frame_end) begin
        // A valid load on the last cycle bypasses the shadow and applies directly.
        hc     <= '0;
        vc     <= '0;
        pend_q <= 1'b0;
        if (load_ok)     act <= cfg;
        else if (pend_q) act <= shd;
      end else begin
        hc <= line_end ? '0 : hc + BitWidth'(1);
        if (line_end) vc <= vc + BitHeight'(1);
        if (load_ok) begin
          shd    <= cfg;
          pend_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    de_raw  = (hc < act.h_active) && (vc < act.v_active);
    hs_raw  = ({2'b00, hc} >= hs_beg) && ({2'b00, hc} < hs_end);
    vs_raw  = ({2'b00, vc} >= vs_beg) && ({2'b00, vc} < vs_end);
    sof_raw = (hc == '0) && (vc == '0);
    eol_raw = (hc == act.h_active - BitWidth'(1)) && (vc < act.v_active);
    vid_d   = {de_raw, ~(hs_raw ^ act.hs_pol), ~(vs_raw ^ act.vs_pol), sof_raw, eol_raw};
  end

  h14tx_delay_line #(
    .Width (5),
    .Depth (Latency),
    .RstVal(VidRst)
  ) u_dly (
    .clk(clk),
    .rst(rst),
    .d  (vid_d),
    .q  (vid_q)
  );

  assign x           = hc;
  assign y           = vc;
  assign cfg_pending = pend_q;
  assign cfg_err     = err_q;
  assign {de, hsync, vsync, sof, eol} = vid_q;

endmodule

// File: tb/tb_h14tx_vtg.sv
// Scoreboard bench for h14tx_vtg: cycle model of counters/shadow, queued video flags,
// plus a 720p Latency=0 instance checked over its first two lines.
module tb_h14tx_vtg;
  import h14tx_pkg::*;

  localparam int unsigned Lat = 2;

  localparam vtg_timing_t Tiny  = '{h_active: 12'd8, h_fp: 12'd2, h_sync: 12'd3, h_bp: 12'd2,
                                    v_active: 11'd4, v_fp: 11'd1, v_sync: 11'd2, v_bp: 11'd1,
                                    hs_pol: 1'b1, vs_pol: 1'b1};
  localparam vtg_timing_t TimA  = '{h_active: 12'd6, h_fp: 12'd1, h_sync: 12'd2, h_bp: 12'd3,
                                    v_active: 11'd3, v_fp: 11'd2, v_sync: 11'd1, v_bp: 11'd2,
                                    hs_pol: 1'b0, vs_pol: 1'b0};
  localparam vtg_timing_t TimB  = '{h_active: 12'd10, h_fp: 12'd2, h_sync: 12'd2, h_bp: 12'd1,
                                    v_active: 11'd5, v_fp: 11'd1, v_sync: 11'd1, v_bp: 11'd1,
                                    hs_pol: 1'b1, vs_pol: 1'b0};
  localparam vtg_timing_t TimC  = '{h_active: 12'd5, h_fp: 12'd1, h_sync: 12'd1, h_bp: 12'd1,
                                    v_active: 11'd2, v_fp: 11'd1, v_sync: 11'd1, v_bp: 11'd1,
                                    hs_pol: 1'b1, vs_pol: 1'b1};
  localparam vtg_timing_t Bad0  = '{h_active: 12'd0, h_fp: 12'd1, h_sync: 12'd2, h_bp: 12'd3,
                                    v_active: 11'd3, v_fp: 11'd2, v_sync: 11'd1, v_bp: 11'd2,
                                    hs_pol: 1'b0, vs_pol: 1'b0};
  localparam vtg_timing_t BadV  = '{h_active: 12'd6, h_fp: 12'd1, h_sync: 12'd2, h_bp: 12'd3,
                                    v_active: 11'd3, v_fp: 11'd2, v_sync: 11'd0, v_bp: 11'd2,
                                    hs_pol: 1'b0, vs_pol: 1'b0};
  localparam vtg_timing_t BadH  = '{h_active: 12'd4000, h_fp: 12'd50, h_sync: 12'd40, h_bp: 12'd7,
                                    v_active: 11'd3, v_fp: 11'd2, v_sync: 11'd1, v_bp: 11'd2,
                                    hs_pol: 1'b1, vs_pol: 1'b1};
  localparam vtg_timing_t BadVt = '{h_active: 12'd6, h_fp: 12'd1, h_sync: 12'd2, h_bp: 12'd3,
                                    v_active: 11'd2040, v_fp: 11'd4, v_sync: 11'd2, v_bp: 11'd3,
                                    hs_pol: 1'b1, vs_pol: 1'b1};
  localparam vtg_timing_t MaxH  = '{h_active: 12'd4000, h_fp: 12'd50, h_sync: 12'd40, h_bp: 12'd6,
                                    v_active: 11'd3, v_fp: 11'd2, v_sync: 11'd1, v_bp: 11'd2,
                                    hs_pol: 1'b1, vs_pol: 1'b1};
  localparam logic [4:0] RstVid = {1'b0, ~Tiny.hs_pol, ~Tiny.vs_pol, 2'b00};

  logic        clk = 1'b0;
  logic        rst = 1'b1, cfg_load = 1'b0, rst720 = 1'b1;
  vtg_timing_t cfg = '0, cfg720 = '0;
  logic        cfg_pending, cfg_err, de, hsync, vsync, sof, eol;
  logic [11:0] x;
  logic [10:0] y;
  logic        pend2, err2, de2, hs2, vs2, sof2, eol2;
  logic [11:0] x2;
  logic [10:0] y2;
`ifdef H14TX_VTG_GENLOCK_EN
  logic        locked1, locked2;
`endif

  always #5 clk = ~clk;

  h14tx_vtg #(.Latency(Lat), .ResetTiming(Tiny)) dut (
    .clk(clk), .rst(rst), .cfg(cfg), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err), .x(x), .y(y),
    .de(de), .hsync(hsync), .vsync(vsync), .sof(sof), .eol(eol)
`ifdef H14TX_VTG_GENLOCK_EN
    , .ext_lock(1'b0), .locked(locked1)
`endif
  );

  h14tx_vtg #(.Latency(0)) dut720 (
    .clk(clk), .rst(rst720), .cfg(cfg720), .cfg_load(1'b0),
    .cfg_pending(pend2), .cfg_err(err2), .x(x2), .y(y2),
    .de(de2), .hsync(hs2), .vsync(vs2), .sof(sof2), .eol(eol2)
`ifdef H14TX_VTG_GENLOCK_EN
    , .ext_lock(1'b0), .locked(locked2)
`endif
  );

  int unsigned vectors = 0, miscompares = 0;
  int          mhc = 0, mvc = 0;
  vtg_timing_t mact = Tiny, mshd = Tiny;
  bit          mpend = 0, merr = 0;
  logic [4:0]  vq [$];

  function automatic int htotal(input vtg_timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int vtotal(input vtg_timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

  function automatic bit valid(input vtg_timing_t t);
    return t.h_active != 0 && t.h_sync != 0 && t.v_active != 0 && t.v_sync != 0
        && htotal(t) <= 4096 && vtotal(t) <= 2048;
  endfunction

  function automatic logic [4:0] model_vid();
    int  hb, vb;
    bit  d, hs, vs;
    hb = int'(mact.h_active) + int'(mact.h_fp);
    vb = int'(mact.v_active) + int'(mact.v_fp);
    d  = mhc < int'(mact.h_active) && mvc < int'(mact.v_active);
    hs = mhc >= hb && mhc < hb + int'(mact.h_sync);
    vs = mvc >= vb && mvc < vb + int'(mact.v_sync);
    return {d, hs ? mact.hs_pol : ~mact.hs_pol, vs ? mact.vs_pol : ~mact.vs_pol,
            mhc == 0 && mvc == 0, mhc == int'(mact.h_active) - 1 && mvc < int'(mact.v_active)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit ld, input vtg_timing_t c);
    int ht, vt;
    bit ok;
    rst = r; cfg_load = ld; cfg = c;
    @(posedge clk);
    ht = htotal(mact);
    vt = vtotal(mact);
    ok = ld && valid(c);
    if (r) begin
      mhc = 0; mvc = 0; mact = Tiny; mshd = Tiny; mpend = 0; merr = 0;
      vq.delete();
      repeat (Lat) vq.push_back(RstVid);
    end else begin
      merr = ld && !ok;
      if (mhc == ht - 1 && mvc == vt - 1) begin
        mhc = 0; mvc = 0;
        if (ok) mact = c;
        else if (mpend) mact = mshd;
        mpend = 0;
      end else begin
        if (mhc == ht - 1) begin mhc = 0; mvc++; end
        else mhc++;
        if (ok) begin mshd = c; mpend = 1; end
      end
    end
    #1;
    check("x", 32'(x), mhc);
    check("y", 32'(y), mvc);
    check("cfg_pending", 32'(cfg_pending), 32'(mpend));
    check("cfg_err", 32'(cfg_err), 32'(merr));
    vq.push_back(model_vid());
    check("de_hs_vs_sof_eol", 32'({de, hsync, vsync, sof, eol}), 32'(vq.pop_front()));
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0);
  endtask

  task automatic run_to_last();
    for (int i = 0; i < 5000 && !(mhc == htotal(mact) - 1 && mvc == vtotal(mact) - 1); i++)
      idle(1);
    check("reach_frame_end", 32'(mhc == htotal(mact) - 1 && mvc == vtotal(mact) - 1), 32'd1);
  endtask

  initial begin
    // reset (load during reset is ignored) and free-running default frames
    step(1, 1, TimA);
    step(1, 0, '0);
    step(1, 0, '0);
    idle(250);
    // mid-frame load waits for the frame boundary
    idle(20);
    step(0, 1, TimA);
    idle(10);
    run_to_last();
    idle(110);
    // several loads in one frame: last valid wins, invalid ones pulse cfg_err only
    idle(5);
    step(0, 1, TimB);
    idle(3);
    step(0, 1, MaxH);
    step(0, 1, TimC);
    step(0, 1, Bad0);
    step(0, 1, BadV);
    step(0, 1, BadH);
    step(0, 1, BadVt);
    run_to_last();
    idle(50);
    // load on the final cycle applies immediately
    run_to_last();
    step(0, 1, TimB);
    idle(130);
    // final-cycle load overrides an already pending shadow
    step(0, 1, TimA);
    run_to_last();
    step(0, 1, TimC);
    idle(45);
    // reset mid-frame with a load pending
    idle(40);
    step(0, 1, TimA);
    idle(7);
    step(1, 0, '0);
    idle(130);

    // 720p default timing on the zero-latency instance
    rst720 = 1'b1;
    idle(1);
    rst720 = 1'b0;
    check("720_pending", 32'(pend2), 32'd0);
    for (int k = 0; k < 3300; k++) begin
      check("720_x", 32'(x2), 32'(k % 1650));
      check("720_y", 32'(y2), 32'(k / 1650));
      check("720_de", 32'(de2), 32'((k % 1650) < 1280));
      check("720_hsync", 32'(hs2), 32'((k % 1650) >= 1390 && (k % 1650) < 1430));
      check("720_vsync", 32'(vs2), 32'd0);
      check("720_sof", 32'(sof2), 32'(k == 0));
      idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
